// File: rtl/rr_fifo_arb_pkg.sv
// Shared width helpers and round-robin pointer functions for rr_fifo_arbiter_param
// and sync_fifo. Channel masks are passed zero-extended to MAX_CH bits.
package rr_fifo_arb_pkg;

  localparam int MAX_CH   = 64;
  localparam int MAX_CH_W = 6;

  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int next_rr_ptr(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

  // Returns the first set channel scanning ptr, ptr+1, ... mod n, or -1 if none.
  // Scanning downwards lets the lowest rotated offset win without a found flag.
  function automatic int find_first_from(input int ptr, input logic [MAX_CH-1:0] nonempty,
                                         input int n);
    int res;
    int idx;
    res = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (nonempty[MAX_CH_W'(idx)]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Per-channel synchronous FIFO: drops writes when full and latches a sticky
// overflow flag that only reset clears.
module sync_fifo
  import rr_fifo_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A pop in the same cycle does not rescue a write to a full FIFO.
      if (push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rr_fifo_arbiter_param.sv
// Round-robin arbiter draining NUM_CH private FIFOs onto one registered valid/ready port.
// RR_FIFO_ARB_WORK_CONSERVING_EN selects skip-empty arbitration; otherwise strict slot rotation.
module rr_fifo_arbiter_param
  import rr_fifo_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int CH_W  = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        wen,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     ready,
  output logic                     valid,
  output logic [DATA_W-1:0]        dout,
  output logic [CH_W-1:0]          ch_id
);

  logic [NUM_CH-1:0]             empty;
  logic [NUM_CH-1:0]             pop;
  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [CH_W-1:0]               ptr;
  logic [CH_W-1:0]               ptr_nxt;
  logic [CH_W-1:0]               gsel;
  logic                          grant_ok;
  logic                          load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (wen[i]),
      .pop      (pop[i]),
      .din      (din[i*DATA_W +: DATA_W]),
      .head     (head[i]),
      .empty    (empty[i]),
      .full     (full[i]),
      .overflow (overflow[i])
    );
  end

  assign load = !valid || ready;

`ifdef RR_FIFO_ARB_WORK_CONSERVING_EN
  logic [MAX_CH-1:0] nonempty_ext;
  int                g_first;

  always_comb begin
    nonempty_ext               = '0;
    nonempty_ext[NUM_CH-1:0]   = ~empty;
    g_first                    = find_first_from(int'(ptr), nonempty_ext, NUM_CH);
    grant_ok                   = 1'b0;
    gsel                       = ptr;
    if (g_first >= 0) begin
      grant_ok = 1'b1;
      gsel     = CH_W'(g_first);
    end
    ptr_nxt = grant_ok ? CH_W'(next_rr_ptr(int'(gsel), NUM_CH)) : ptr;
  end
`else
  // The slot advances on every load cycle whether or not its channel had data.
  always_comb begin
    gsel     = ptr;
    grant_ok = !empty[ptr];
    ptr_nxt  = CH_W'(next_rr_ptr(int'(ptr), NUM_CH));
  end
`endif

  assign pop = (load && grant_ok) ? (NUM_CH'(1) << gsel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
      ch_id <= '0;
      ptr   <= '0;
    end else if (load) begin
      valid <= grant_ok;
      dout  <= grant_ok ? head[gsel] : '0;
      ch_id <= grant_ok ? gsel : '0;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter_param.sv
// Directed self-checking bench for rr_fifo_arbiter_param (NUM_CH=4, DATA_W=8, DEPTH=8).
// Expected sequences follow RR_FIFO_ARB_WORK_CONSERVING_EN when it is defined for the build.
module tb_rr_fifo_arbiter_param;

`ifdef RR_FIFO_ARB_WORK_CONSERVING_EN
  localparam int GAP = 1;
  localparam int BN  = 5;
  localparam logic [10:0] BEXP [BN] = '{
    {1'b1, 8'd9,   2'd2}, {1'b1, 8'd13, 2'd3}, {1'b1, 8'd139, 2'd2},
    {1'b1, 8'd85,  2'd3}, {1'b0, 8'd0,  2'd0}};
`else
  // Strict slots: a channel is served once every 4 load cycles.
  localparam int GAP = 4;
  localparam int BN  = 7;
  localparam logic [10:0] BEXP [BN] = '{
    {1'b1, 8'd9,   2'd2}, {1'b1, 8'd13, 2'd3}, {1'b0, 8'd0, 2'd0},
    {1'b0, 8'd0,   2'd0}, {1'b1, 8'd139, 2'd2}, {1'b1, 8'd85, 2'd3},
    {1'b0, 8'd0,   2'd0}};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wen;
  logic [31:0] din;
  logic [3:0]  full;
  logic [3:0]  overflow;
  logic        ready;
  logic        valid;
  logic [7:0]  dout;
  logic [1:0]  ch_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_fifo_arbiter_param #(.NUM_CH(4), .DATA_W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .din      (din),
    .full     (full),
    .overflow (overflow),
    .ready    (ready),
    .valid    (valid),
    .dout     (dout),
    .ch_id    (ch_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [1:0] ec);
    chk({tag, " valid"}, 32'(valid), 32'(ev));
    chk({tag, " dout"},  32'(dout),  32'(ed));
    chk({tag, " ch_id"}, 32'(ch_id), 32'(ec));
  endtask

  // Release lands 1 time unit after an edge; the next edge is edge 0 of the test.
  task automatic do_reset();
    rst_n = 1'b0;
    wen   = '0;
    din   = '0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [10:0] e;
    int sent;
    int got;
    int cyc;

    // Basic: three idle edges put the strict slot pointer back on ch0 after the write.
    do_reset();
    chk_out("reset", 1'b0, 8'd0, 2'd0);
    chk("reset full", 32'(full), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    repeat (3) tick();
    wen = 4'b1111; din = {8'd13, 8'd9, 8'd56, 8'd87};
    tick();
    chk_out("basic w", 1'b0, 8'd0, 2'd0);
    wen = 4'b1000; din = {8'd85, 24'd0};
    tick();
    chk_out("basic 0", 1'b1, 8'd87, 2'd0);
    wen = 4'b0100; din = {8'd0, 8'd139, 16'd0};
    tick();
    chk_out("basic 1", 1'b1, 8'd56, 2'd1);
    wen = '0; din = '0;
    for (int k = 0; k < BN; k++) begin
      e = BEXP[k];
      tick();
      chk_out($sformatf("basic %0d", k + 2), e[10], e[9:2], e[1:0]);
    end

    // Backpressure on ch0.
    do_reset();
    repeat (3) tick();
    wen = 4'b0001; din = 32'd1;
    tick();
    chk_out("bp w", 1'b0, 8'd0, 2'd0);
    din = 32'd2;
    tick();
    chk_out("bp first", 1'b1, 8'd1, 2'd0);
    ready = 1'b0;
    din = 32'd3;
    tick();
    chk_out("bp hold 0", 1'b1, 8'd1, 2'd0);
    wen = '0; din = '0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_out($sformatf("bp hold %0d", k), 1'b1, 8'd1, 2'd0);
    end
    ready = 1'b1;
    for (int w = 2; w <= 3; w++) begin
      repeat (GAP - 1) begin
        tick();
        chk_out("bp gap", 1'b0, 8'd0, 2'd0);
      end
      tick();
      chk_out($sformatf("bp word %0d", w), 1'b1, 8'(w), 2'd0);
    end
    tick();
    chk_out("bp drained", 1'b0, 8'd0, 2'd0);

    // Overflow: 10 writes into ch0 under ready=0; 10 sits in the output register.
    do_reset();
    repeat (3) tick();
    ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wen = 4'b0001; din = 32'(10 + k);
      tick();
      if (k == 1) chk_out("ovf first", 1'b1, 8'd10, 2'd0);
      if (k == 7) chk("ovf not yet full", 32'(full), 32'h0);
      if (k == 8) begin
        chk("ovf full", 32'(full), 32'h1);
        chk("ovf not yet set", 32'(overflow), 32'h0);
      end
    end
    chk("ovf set", 32'(overflow), 32'h1);
    chk("ovf full held", 32'(full), 32'h1);
    chk_out("ovf hold", 1'b1, 8'd10, 2'd0);
    wen = '0; din = '0; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      repeat (GAP - 1) begin
        tick();
        chk_out("ovf gap", 1'b0, 8'd0, 2'd0);
      end
      tick();
      chk_out($sformatf("ovf word %0d", 11 + k), 1'b1, 8'(11 + k), 2'd0);
    end
    tick();
    chk_out("ovf no 19", 1'b0, 8'd0, 2'd0);
    chk("ovf sticky", 32'(overflow), 32'h1);
    chk("ovf full cleared", 32'(full), 32'h0);

    // Asynchronous reset mid-operation with every FIFO full and the output held.
    ready = 1'b0;
    wen = 4'b1111; din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    repeat (10) tick();
    wen = '0; din = '0;
    chk("pre-rst valid", 32'(valid), 32'h1);
    chk("pre-rst full", 32'(full), 32'hF);
    chk("pre-rst overflow", 32'(overflow), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async rst", 1'b0, 8'd0, 2'd0);
    chk("async rst full", 32'(full), 32'h0);
    chk("async rst overflow", 32'(overflow), 32'h0);
    ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("post-rst %0d", k), 1'b0, 8'd0, 2'd0);
    end

    // Wrap-around: 20 words through ch1, occupancy kept below DEPTH.
    do_reset();
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 400) begin
      if (sent < 20 && (sent - got) < 6) begin
        wen = 4'b0010; din = (32'h40 + 32'(sent)) << 8;
        sent++;
      end else begin
        wen = '0; din = '0;
      end
      tick();
      cyc++;
      if (valid) begin
        chk($sformatf("wrap data %0d", got), 32'(dout), 32'h40 + 32'(got));
        chk("wrap ch_id", 32'(ch_id), 32'h1);
        got++;
      end
    end
    wen = '0; din = '0;
    chk("wrap count", 32'(got), 32'd20);
    chk("wrap overflow", 32'(overflow), 32'h0);
    tick();
    chk_out("wrap drained", 1'b0, 8'd0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
